mf_feeder: RTL and testbench

Front-end driver for the 20-tap matched filter. Accepts a serial stream of signed samples, maintains a 20-deep sliding window, and holds a double-buffered bank of 20 coefficients. Once the window is full, it presents the window and the active coefficients in parallel with a one-cycle `pushout` strobe, which connects directly to the filter's `pushin`/`dinNN`/`winNN` inputs. It has no backpressure: the filter accepts one push per cycle unconditionally.

---
 rtl/mf_feeder_if.sv | 47 ++++
 rtl/mf_feeder.sv | 177 +++++++++++++++++
 tb/tb_mf_feeder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mf_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : mf_feeder_if
// Description : Bus bundle between a sample/coefficient source and the
//               matched-filter feeder. The master side drives samples, flush
//               and coefficient writes. The slave side (the feeder) returns
//               the push strobe, the parallel window, the active coefficients
//               and the fill status.
// Signals     : samp_valid/samp_data   serial sample stream
//               flush                  discard window, restart fill
//               coef_we/addr/data      shadow coefficient write port
//               coef_commit            shadow -> active bank copy
//               pushout                one-cycle strobe to the filter
//               dout[0..19]            window, dout[0] newest
//               wout[0..19]            active coefficient bank
//               full/fill_cnt          window fill status
// Revision    : 1.0 - initial release
// ============================================================================
interface mf_feeder_if #(
    parameter int WIDTH = 32
);
    logic                    samp_valid;
    logic signed [WIDTH-1:0] samp_data;
    logic                    flush;
    logic                    coef_we;
    logic [4:0]              coef_addr;
    logic signed [WIDTH-1:0] coef_data;
    logic                    coef_commit;
    logic                    pushout;
    logic signed [WIDTH-1:0] dout [20];
    logic signed [WIDTH-1:0] wout [20];
    logic                    full;
    logic [4:0]              fill_cnt;

    modport master (
        output samp_valid, samp_data, flush,
        output coef_we, coef_addr, coef_data, coef_commit,
        input  pushout, dout, wout, full, fill_cnt
    );

    modport slave (
        input  samp_valid, samp_data, flush,
        input  coef_we, coef_addr, coef_data, coef_commit,
        output pushout, dout, wout, full, fill_cnt
    );
endinterface
`default_nettype wire

// File: rtl/mf_feeder.sv
`default_nettype none
// ============================================================================
// Module      : mf_feeder
// Description : Front end of the 20-tap matched filter. Keeps a 20-deep
//               sliding window of accepted samples and a double-buffered
//               coefficient bank. Once the window is full it emits a
//               one-cycle push every DECIM accepted samples, presenting the
//               window and active coefficients in parallel.
// Ports       : clk    rising-edge clock
//               reset  synchronous, active-high reset
//               bus    mf_feeder_if.slave (samples, flush, coefficient port,
//                      push strobe, window, coefficients, fill status)
// Parameters  : WIDTH  sample/coefficient width (signed)
//               DECIM  decimation factor, 1..16
// Revision    : 1.0 - initial release
// ============================================================================
module mf_feeder #(
    parameter int WIDTH = 32,
    parameter int DECIM = 1
) (
    input  wire logic    clk,
    input  wire logic    reset,
    mf_feeder_if.slave   bus
);

    localparam int         c_TAPS     = 20;
    localparam logic [4:0] c_FULL     = 5'd20;
    localparam logic [4:0] c_LAST_FIL = 5'd19;
    localparam logic [3:0] c_PH_LAST  = 4'(DECIM - 1);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic [4:0]              r_fill;
    logic [4:0]              w_fill_nxt;
    logic [3:0]              r_ph;
    logic [3:0]              w_ph_nxt;
    logic                    r_push;
    logic                    w_push;
    logic signed [WIDTH-1:0] r_dout     [c_TAPS];
    logic signed [WIDTH-1:0] r_shadow   [c_TAPS];
    logic signed [WIDTH-1:0] r_wout     [c_TAPS];
    logic signed [WIDTH-1:0] w_shadow_nxt [c_TAPS];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. Only an accept or a flush moves the state; a flush
    // that coincides with an accept lands in FILL because that sample is
    // loaded into the freshly cleared window.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (bus.flush) begin
            w_state_nxt = bus.samp_valid ? S_FILL : S_EMPTY;
        end else if (bus.samp_valid) begin
            case (r_state)
                S_EMPTY: w_state_nxt = S_FILL;
                S_FILL:  w_state_nxt = (r_fill == c_LAST_FIL) ? S_RUN : S_FILL;
                S_RUN:   w_state_nxt = S_RUN;
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs (push decision, fill count, decimation phase).
    // The phase only advances on accepts that leave the FSM in RUN, which
    // includes the accept completing the window. Outside RUN it stays at
    // zero, so the first full window always pushes.
    // ------------------------------------------------------------------
    always_comb begin
        w_push     = 1'b0;
        w_fill_nxt = r_fill;
        w_ph_nxt   = r_ph;
        if (bus.flush) begin
            w_fill_nxt = {4'd0, bus.samp_valid};
            w_ph_nxt   = 4'd0;
        end else if (bus.samp_valid) begin
            w_fill_nxt = (r_fill == c_FULL) ? c_FULL : r_fill + 5'd1;
            if (w_state_nxt == S_RUN) begin
                w_push   = (r_ph == 4'd0);
                w_ph_nxt = (r_ph == c_PH_LAST) ? 4'd0 : r_ph + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fill <= 5'd0;
            r_ph   <= 4'd0;
            r_push <= 1'b0;
        end else begin
            r_fill <= w_fill_nxt;
            r_ph   <= w_ph_nxt;
            r_push <= w_push;
        end
    end

    // ------------------------------------------------------------------
    // Sample window
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < c_TAPS; k++) begin
                r_dout[k] <= '0;
            end
        end else if (bus.flush) begin
            for (int k = 1; k < c_TAPS; k++) begin
                r_dout[k] <= '0;
            end
            r_dout[0] <= bus.samp_valid ? bus.samp_data : '0;
        end else if (bus.samp_valid) begin
            r_dout[0] <= bus.samp_data;
            for (int k = 1; k < c_TAPS; k++) begin
                r_dout[k] <= r_dout[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Coefficient banks. The merged shadow image (current shadow plus this
    // cycle's write) feeds both the shadow register and the commit path so
    // that a write and commit in the same cycle commit the new value.
    // Addresses 20..31 match no entry and are dropped.
    // ------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < c_TAPS; k++) begin
            w_shadow_nxt[k] = r_shadow[k];
            if (bus.coef_we && (bus.coef_addr == 5'(k))) begin
                w_shadow_nxt[k] = bus.coef_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < c_TAPS; k++) begin
                r_shadow[k] <= '0;
                r_wout[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < c_TAPS; k++) begin
                r_shadow[k] <= w_shadow_nxt[k];
                if (bus.coef_commit) begin
                    r_wout[k] <= w_shadow_nxt[k];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.pushout  = r_push;
    assign bus.fill_cnt = r_fill;
    assign bus.full     = (r_fill == c_FULL);

    for (genvar g = 0; g < c_TAPS; g++) begin : g_tap
        assign bus.dout[g] = r_dout[g];
        assign bus.wout[g] = r_wout[g];
    end

endmodule
`default_nettype wire

// File: tb/tb_mf_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mf_feeder
// Description : Directed testbench for mf_feeder. Two instances (DECIM=1 and
//               DECIM=3) receive identical stimulus; expected values are
//               hand-derived constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mf_feeder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mf_feeder_if #(.WIDTH(32)) if1 ();
    mf_feeder_if #(.WIDTH(32)) if3 ();

    mf_feeder #(.WIDTH(32), .DECIM(1)) u_dut1 (.clk(clk), .reset(rst), .bus(if1.slave));
    mf_feeder #(.WIDTH(32), .DECIM(3)) u_dut3 (.clk(clk), .reset(rst), .bus(if3.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle of stimulus to both instances; returns #1 after the edge.
    task automatic cyc(input logic v, input logic [31:0] d, input logic fl,
                       input logic we, input logic [4:0] a, input logic [31:0] cd,
                       input logic cm);
        if1.samp_valid = v;  if3.samp_valid = v;
        if1.samp_data  = d;  if3.samp_data  = d;
        if1.flush      = fl; if3.flush      = fl;
        if1.coef_we    = we; if3.coef_we    = we;
        if1.coef_addr  = a;  if3.coef_addr  = a;
        if1.coef_data  = cd; if3.coef_data  = cd;
        if1.coef_commit = cm; if3.coef_commit = cm;
        @(posedge clk);
        #1;
    endtask

    task automatic samp(input logic [31:0] d);
        cyc(1'b1, d, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        idle();
        idle();
        chk("rst_push",  {31'd0, if1.pushout},  32'd0);
        chk("rst_fill",  {27'd0, if1.fill_cnt}, 32'd0);
        chk("rst_full",  {31'd0, if1.full},     32'd0);
        chk("rst_dout0", if1.dout[0],           32'd0);
        chk("rst_wout0", if1.wout[0],           32'd0);
        rst = 1'b0;
        idle();

        // Coefficients k+1 into shadow, then commit
        for (int k = 0; k < 20; k++) begin
            cyc(1'b0, 32'd0, 1'b0, 1'b1, 5'(k), 32'(k + 1), 1'b0);
        end
        chk("wout0_precommit", if1.wout[0], 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        chk("wout0_commit",  if1.wout[0],  32'd1);
        chk("wout19_commit", if1.wout[19], 32'd20);

        // Fill and decimation: samples 1..30 back-to-back
        for (int i = 1; i <= 30; i++) begin
            samp(32'(i));
            chk("fill_push1", {31'd0, if1.pushout}, {31'd0, (i >= 20)});
            chk("fill_push3", {31'd0, if3.pushout},
                {31'd0, (i == 20 || i == 23 || i == 26 || i == 29)});
            if (i == 19) begin
                chk("fill19_cnt",  {27'd0, if1.fill_cnt}, 32'd19);
                chk("fill19_full", {31'd0, if1.full},     32'd0);
            end
            if (i == 20) begin
                chk("first_dout0",  if1.dout[0],  32'd20);
                chk("first_dout19", if1.dout[19], 32'd1);
                chk("first_wout0",  if1.wout[0],  32'd1);
                chk("first_wout19", if1.wout[19], 32'd20);
                chk("first_full",   {31'd0, if1.full}, 32'd1);
            end
            if (i == 23 || i == 26 || i == 29) begin
                chk("dec3_dout0", if3.dout[0], 32'(i));
            end
        end
        chk("sat_fill", {27'd0, if1.fill_cnt}, 32'd20);

        // Gapped input: valid 1,0,1,0 with samples 31, 32
        samp(32'd31);
        chk("gap_push_a", {31'd0, if1.pushout}, 32'd1);
        chk("gap_dout0_a", if1.dout[0], 32'd31);
        chk("gap_push3_a", {31'd0, if3.pushout}, 32'd0);
        idle();
        chk("gap_push_b", {31'd0, if1.pushout}, 32'd0);
        chk("gap_dout0_b", if1.dout[0], 32'd31);
        chk("gap_dout1_b", if1.dout[1], 32'd30);
        samp(32'd32);
        chk("gap_push_c", {31'd0, if1.pushout}, 32'd1);
        chk("gap_dout1_c", if1.dout[1], 32'd31);
        chk("gap_push3_c", {31'd0, if3.pushout}, 32'd1);
        idle();
        chk("gap_push_d", {31'd0, if1.pushout}, 32'd0);
        chk("gap_dout0_d", if1.dout[0], 32'd32);

        // Coefficient double buffer
        cyc(1'b1, 32'd33, 1'b0, 1'b1, 5'd3, 32'h7FFF_FFFF, 1'b0);
        chk("dbuf_push",     {31'd0, if1.pushout}, 32'd1);
        chk("dbuf_wout3_old", if1.wout[3], 32'd4);
        cyc(1'b1, 32'd34, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        chk("dbuf_push_cm",   {31'd0, if1.pushout}, 32'd1);
        chk("dbuf_wout3_new", if1.wout[3], 32'h7FFF_FFFF);
        cyc(1'b1, 32'd35, 1'b0, 1'b1, 5'd25, 32'h1234, 1'b1);
        chk("addr25_wout0",  if1.wout[0],  32'd1);
        chk("addr25_wout19", if1.wout[19], 32'd20);
        chk("addr25_wout3",  if1.wout[3],  32'h7FFF_FFFF);
        cyc(1'b1, 32'd36, 1'b0, 1'b1, 5'd5, 32'hFFFF_FFF7, 1'b1);
        chk("we_cm_wout5", if1.wout[5], 32'hFFFF_FFF7);
        chk("we_cm_wout4", if1.wout[4], 32'd5);

        // Flush collision with a sample of -5
        cyc(1'b1, 32'hFFFF_FFFB, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("flush_push",  {31'd0, if1.pushout}, 32'd0);
        chk("flush_push3", {31'd0, if3.pushout}, 32'd0);
        chk("flush_fill",  {27'd0, if1.fill_cnt}, 32'd1);
        chk("flush_full",  {31'd0, if1.full}, 32'd0);
        chk("flush_dout0", if1.dout[0],  32'hFFFF_FFFB);
        chk("flush_dout1", if1.dout[1],  32'd0);
        chk("flush_dout19", if1.dout[19], 32'd0);
        for (int j = 1; j <= 19; j++) begin
            samp(32'(100 + j));
            chk("refill_push1", {31'd0, if1.pushout}, {31'd0, (j == 19)});
        end
        chk("refill_push3", {31'd0, if3.pushout}, 32'd1);
        chk("refill_dout0",  if1.dout[0],  32'd119);
        chk("refill_dout18", if1.dout[18], 32'd101);
        chk("refill_dout19", if1.dout[19], 32'hFFFF_FFFB);

        // Reset mid-stream with a valid sample present
        rst = 1'b1;
        samp(32'd77);
        chk("mrst_push",  {31'd0, if1.pushout}, 32'd0);
        chk("mrst_dout0", if1.dout[0],  32'd0);
        chk("mrst_dout19", if1.dout[19], 32'd0);
        chk("mrst_wout3", if1.wout[3],  32'd0);
        chk("mrst_fill",  {27'd0, if1.fill_cnt}, 32'd0);
        chk("mrst_full",  {31'd0, if1.full}, 32'd0);
        rst = 1'b0;
        samp(32'd5);
        chk("post_rst_fill",  {27'd0, if1.fill_cnt}, 32'd1);
        chk("post_rst_dout0", if1.dout[0], 32'd5);
        chk("post_rst_push",  {31'd0, if1.pushout}, 32'd0);
        chk("post_rst_wout0", if1.wout[0], 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
